// File: rtl/dma_pcis_resp_framer_if.sv
// Bus bundle for dma_pcis_resp_framer: AR/AW commands, W-channel monitor, B response,
// 512b result stream and R channel. The framer connects through the slave modport.
interface dma_pcis_resp_framer_if #(
    parameter int DATA_W = 512,
    parameter int ID_W   = 6,
    parameter int LEN_W  = 8
) ();
    logic [ID_W-1:0]   s_arid;
    logic [LEN_W-1:0]  s_arlen;
    logic              s_arvalid;
    logic              s_arready;
    logic [ID_W-1:0]   s_awid;
    logic              s_awvalid;
    logic              s_awready;
    logic              mon_wvalid;
    logic              mon_wready;
    logic              mon_wlast;
    logic [ID_W-1:0]   s_bid;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready;
    logic [DATA_W-1:0] st_tdata;
    logic              st_tvalid;
    logic              st_tready;
    logic [ID_W-1:0]   s_rid;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast;
    logic              s_rvalid;
    logic              s_rready;

    modport slave (
        input  s_arid, s_arlen, s_arvalid,
        output s_arready,
        input  s_awid, s_awvalid,
        output s_awready,
        input  mon_wvalid, mon_wready, mon_wlast,
        output s_bid, s_bresp, s_bvalid,
        input  s_bready,
        input  st_tdata, st_tvalid,
        output st_tready,
        output s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        input  s_rready
    );

    modport master (
        output s_arid, s_arlen, s_arvalid,
        input  s_arready,
        output s_awid, s_awvalid,
        input  s_awready,
        output mon_wvalid, mon_wready, mon_wlast,
        input  s_bid, s_bresp, s_bvalid,
        output s_bready,
        output st_tdata, st_tvalid,
        input  st_tready,
        input  s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        output s_rready
    );
endinterface

// File: rtl/dma_pcis_resp_framer.sv
// AXI response framer for the DMA PCIS slave: frames the result stream into R bursts per AR
// and pairs completed W bursts with AWs for B. Optional stall timeout: RESP_FRAMER_TIMEOUT_EN.
module dma_pcis_resp_framer #(
    parameter int DATA_W      = 512,
    parameter int ID_W        = 6,
    parameter int LEN_W       = 8,
    parameter int CMD_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dma_pcis_resp_framer_if.slave bus
);
    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(CMD_DEPTH);

    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("CMD_DEPTH must be a power of two, at least 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [0:0] {
        RD_IDLE  = 1'b0,
        RD_BURST = 1'b1
    } rd_state_e;

    // ---------------- AR command FIFO ----------------
    logic [ID_W-1:0]  ar_id_mem_q  [CMD_DEPTH];
    logic [LEN_W-1:0] ar_len_mem_q [CMD_DEPTH];
    logic [PTR_W-1:0] ar_wptr_q, ar_rptr_q;
    logic [CNT_W-1:0] ar_cnt_q, ar_cnt_d;
    logic             ar_rdy_q;
    logic             ar_push_s, ar_pop_s, ar_empty_s;

    assign ar_push_s  = bus.s_arvalid & ar_rdy_q;
    assign ar_empty_s = (ar_cnt_q == {CNT_W{1'b0}});

    // AR occupancy next state
    always_comb begin
        ar_cnt_d = ar_cnt_q;
        case ({ar_push_s, ar_pop_s})
            2'b10:   ar_cnt_d = ar_cnt_q + CNT_W'(1);
            2'b01:   ar_cnt_d = ar_cnt_q - CNT_W'(1);
            default: ar_cnt_d = ar_cnt_q;
        endcase
    end

    // AR storage, pointers, and registered ready (low during reset)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CMD_DEPTH; i++) begin
                ar_id_mem_q[i]  <= {ID_W{1'b0}};
                ar_len_mem_q[i] <= {LEN_W{1'b0}};
            end
            ar_wptr_q <= {PTR_W{1'b0}};
            ar_rptr_q <= {PTR_W{1'b0}};
            ar_cnt_q  <= {CNT_W{1'b0}};
            ar_rdy_q  <= 1'b0;
        end else begin
            if (ar_push_s) begin
                ar_id_mem_q[ar_wptr_q]  <= bus.s_arid;
                ar_len_mem_q[ar_wptr_q] <= bus.s_arlen;
                ar_wptr_q               <= ar_wptr_q + PTR_W'(1);
            end
            if (ar_pop_s) begin
                ar_rptr_q <= ar_rptr_q + PTR_W'(1);
            end
            ar_cnt_q <= ar_cnt_d;
            ar_rdy_q <= (ar_cnt_d != DEPTH_C);
        end
    end

    // ---------------- Read framing FSM ----------------
    rd_state_e         state_q, state_d;
    logic [ID_W-1:0]   cmd_id_q, cmd_id_d;
    logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic              rvalid_s, tready_s, rlast_s, r_hs_s;
    logic [DATA_W-1:0] rdata_s;
    logic [ID_W-1:0]   rid_s;
    logic [1:0]        rresp_s;

`ifdef RESP_FRAMER_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [STALL_W-1:0] STALL_LIM_C = STALL_W'(TIMEOUT_CYC - 1);
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               to_q, to_d;
`endif

    // Read FSM next state and R/stream outputs; the stream passes straight through in BURST
    always_comb begin
        state_d   = state_q;
        cmd_id_d  = cmd_id_q;
        cmd_len_d = cmd_len_q;
        beat_d    = beat_q;
        ar_pop_s  = 1'b0;
        rvalid_s  = 1'b0;
        tready_s  = 1'b0;
        rdata_s   = {DATA_W{1'b0}};
        rid_s     = {ID_W{1'b0}};
        rresp_s   = 2'b00;
        rlast_s   = 1'b0;
        r_hs_s    = 1'b0;
`ifdef RESP_FRAMER_TIMEOUT_EN
        stall_d   = stall_q;
        to_d      = to_q;
`endif
        case (state_q)
            RD_IDLE: begin
`ifdef RESP_FRAMER_TIMEOUT_EN
                stall_d = {STALL_W{1'b0}};
                to_d    = 1'b0;
`endif
                if (!ar_empty_s) begin
                    ar_pop_s  = 1'b1;
                    cmd_id_d  = ar_id_mem_q[ar_rptr_q];
                    cmd_len_d = ar_len_mem_q[ar_rptr_q];
                    beat_d    = {LEN_W{1'b0}};
                    state_d   = RD_BURST;
                end else begin
                    state_d   = RD_IDLE;
                end
            end
            RD_BURST: begin
                rid_s   = cmd_id_q;
                rlast_s = (beat_q == cmd_len_q);
`ifdef RESP_FRAMER_TIMEOUT_EN
                // Once timed out, the rest of the burst is synthesised as SLVERR beats
                if (to_q) begin
                    rvalid_s = 1'b1;
                    rresp_s  = 2'b10;
                end else begin
                    rvalid_s = bus.st_tvalid;
                    tready_s = bus.s_rready;
                    rdata_s  = bus.st_tdata;
                    if (bus.st_tvalid) begin
                        stall_d = {STALL_W{1'b0}};
                    end else if (stall_q == STALL_LIM_C) begin
                        stall_d = {STALL_W{1'b0}};
                        to_d    = 1'b1;
                    end else begin
                        stall_d = stall_q + STALL_W'(1);
                    end
                end
`else
                rvalid_s = bus.st_tvalid;
                tready_s = bus.s_rready;
                rdata_s  = bus.st_tdata;
`endif
                r_hs_s = rvalid_s & bus.s_rready;
                if (r_hs_s) begin
                    if (rlast_s) begin
`ifdef RESP_FRAMER_TIMEOUT_EN
                        stall_d = {STALL_W{1'b0}};
                        to_d    = 1'b0;
`endif
                        if (!ar_empty_s) begin
                            ar_pop_s  = 1'b1;
                            cmd_id_d  = ar_id_mem_q[ar_rptr_q];
                            cmd_len_d = ar_len_mem_q[ar_rptr_q];
                            beat_d    = {LEN_W{1'b0}};
                        end else begin
                            state_d   = RD_IDLE;
                        end
                    end else begin
                        beat_d = beat_q + LEN_W'(1);
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    // Read FSM state and command registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RD_IDLE;
            cmd_id_q  <= {ID_W{1'b0}};
            cmd_len_q <= {LEN_W{1'b0}};
            beat_q    <= {LEN_W{1'b0}};
`ifdef RESP_FRAMER_TIMEOUT_EN
            stall_q   <= {STALL_W{1'b0}};
            to_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cmd_id_q  <= cmd_id_d;
            cmd_len_q <= cmd_len_d;
            beat_q    <= beat_d;
`ifdef RESP_FRAMER_TIMEOUT_EN
            stall_q   <= stall_d;
            to_q      <= to_d;
`endif
        end
    end

    // ---------------- Write response path ----------------
    logic [ID_W-1:0]  aw_mem_q [CMD_DEPTH];
    logic [PTR_W-1:0] aw_wptr_q, aw_rptr_q;
    logic [CNT_W-1:0] aw_cnt_q, aw_cnt_d;
    logic             aw_rdy_q;
    logic             aw_push_s, aw_empty_s;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             bvalid_q, bvalid_d;
    logic [ID_W-1:0]  bid_q, bid_d;
    logic             b_hs_s, w_done_s;

    assign aw_push_s  = bus.s_awvalid & aw_rdy_q;
    assign aw_empty_s = (aw_cnt_q == {CNT_W{1'b0}});
    assign b_hs_s     = bvalid_q & bus.s_bready;
    assign w_done_s   = bus.mon_wvalid & bus.mon_wready & bus.mon_wlast;

    // AW occupancy, pending-wlast count and B issue; the B handshake is the AW pop
    always_comb begin
        aw_cnt_d = aw_cnt_q;
        case ({aw_push_s, b_hs_s})
            2'b10:   aw_cnt_d = aw_cnt_q + CNT_W'(1);
            2'b01:   aw_cnt_d = aw_cnt_q - CNT_W'(1);
            default: aw_cnt_d = aw_cnt_q;
        endcase

        pend_d = pend_q;
        if (w_done_s && !b_hs_s && (pend_q != DEPTH_C)) begin
            pend_d = pend_q + CNT_W'(1);
        end else if (!w_done_s && b_hs_s) begin
            pend_d = pend_q - CNT_W'(1);
        end else begin
            pend_d = pend_q;
        end

        bvalid_d = bvalid_q;
        bid_d    = bid_q;
        if (bvalid_q) begin
            bvalid_d = !bus.s_bready;
        end else if ((pend_q != {CNT_W{1'b0}}) && !aw_empty_s) begin
            bvalid_d = 1'b1;
            bid_d    = aw_mem_q[aw_rptr_q];
        end else begin
            bvalid_d = 1'b0;
        end
    end

    // AW storage, pending count and B registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CMD_DEPTH; i++) begin
                aw_mem_q[i] <= {ID_W{1'b0}};
            end
            aw_wptr_q <= {PTR_W{1'b0}};
            aw_rptr_q <= {PTR_W{1'b0}};
            aw_cnt_q  <= {CNT_W{1'b0}};
            aw_rdy_q  <= 1'b0;
            pend_q    <= {CNT_W{1'b0}};
            bvalid_q  <= 1'b0;
            bid_q     <= {ID_W{1'b0}};
        end else begin
            if (aw_push_s) begin
                aw_mem_q[aw_wptr_q] <= bus.s_awid;
                aw_wptr_q           <= aw_wptr_q + PTR_W'(1);
            end
            if (b_hs_s) begin
                aw_rptr_q <= aw_rptr_q + PTR_W'(1);
            end
            aw_cnt_q <= aw_cnt_d;
            aw_rdy_q <= (aw_cnt_d != DEPTH_C);
            pend_q   <= pend_d;
            bvalid_q <= bvalid_d;
            bid_q    <= bid_d;
        end
    end

    assign bus.s_arready = ar_rdy_q;
    assign bus.s_awready = aw_rdy_q;
    assign bus.s_bvalid  = bvalid_q;
    assign bus.s_bid     = bid_q;
    assign bus.s_bresp   = 2'b00;
    assign bus.st_tready = tready_s;
    assign bus.s_rvalid  = rvalid_s;
    assign bus.s_rdata   = rdata_s;
    assign bus.s_rid     = rid_s;
    assign bus.s_rresp   = rresp_s;
    assign bus.s_rlast   = rlast_s;
endmodule

// File: tb/tb_dma_pcis_resp_framer.sv
// Directed self-checking bench for dma_pcis_resp_framer (read framing, B pairing, reset,
// and the stall timeout when RESP_FRAMER_TIMEOUT_EN is defined).
module tb_dma_pcis_resp_framer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    dma_pcis_resp_framer_if #(.DATA_W(512), .ID_W(6), .LEN_W(8)) bus ();

    dma_pcis_resp_framer #(
        .DATA_W(512), .ID_W(6), .LEN_W(8), .CMD_DEPTH(4), .TIMEOUT_CYC(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] dv(input int i);
        dv = {16{32'hC0DE_0000 + 32'(i)}};
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_rvalid(input string tag);
        int n;
        n = 0;
        while (bus.s_rvalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 512'(bus.s_rvalid), 512'(1'b1));
    endtask

    initial begin
        int idx, nr, cnt, n;
        logic cons;
        bus.s_arid = 6'd0; bus.s_arlen = 8'd0; bus.s_arvalid = 1'b0;
        bus.s_awid = 6'd0; bus.s_awvalid = 1'b0;
        bus.mon_wvalid = 1'b0; bus.mon_wready = 1'b0; bus.mon_wlast = 1'b0;
        bus.s_bready = 1'b0; bus.st_tdata = 512'd0; bus.st_tvalid = 1'b0; bus.s_rready = 1'b0;

        // Reset values
        tick(); tick();
        check("rst_arready", 512'(bus.s_arready), 512'(1'b0));
        check("rst_awready", 512'(bus.s_awready), 512'(1'b0));
        check("rst_rvalid",  512'(bus.s_rvalid),  512'(1'b0));
        check("rst_bvalid",  512'(bus.s_bvalid),  512'(1'b0));
        check("rst_tready",  512'(bus.st_tready), 512'(1'b0));
        check("rst_rlast",   512'(bus.s_rlast),   512'(1'b0));
        rst_n = 1'b1;
        tick();
        check("post_rst_arready", 512'(bus.s_arready), 512'(1'b1));
        check("post_rst_awready", 512'(bus.s_awready), 512'(1'b1));

        // T1: id=5 len=3, four beats
        bus.s_arid = 6'd5; bus.s_arlen = 8'd3; bus.s_arvalid = 1'b1;
        tick();
        bus.s_arvalid = 1'b0; bus.s_rready = 1'b1; bus.st_tvalid = 1'b1; bus.st_tdata = dv(0);
        #1;
        check("t1_idle_rvalid", 512'(bus.s_rvalid), 512'(1'b0));
        for (int i = 0; i < 4; i++) begin
            bus.st_tdata = dv(i);
            #1;
            wait_rvalid("t1_wait");
            check("t1_rid",    512'(bus.s_rid),    512'(6'd5));
            check("t1_rdata",  bus.s_rdata,        dv(i));
            check("t1_rlast",  512'(bus.s_rlast),  512'(i == 3));
            check("t1_rresp",  512'(bus.s_rresp),  512'(2'b00));
            check("t1_tready", 512'(bus.st_tready), 512'(1'b1));
            tick();
        end
        bus.st_tvalid = 1'b0;
        #1;
        check("t1_done_rvalid", 512'(bus.s_rvalid), 512'(1'b0));

        // T2: back-to-back len=0 then len=1, no bubble
        bus.s_arid = 6'd1; bus.s_arlen = 8'd0; bus.s_arvalid = 1'b1;
        tick();
        bus.s_arid = 6'd2; bus.s_arlen = 8'd1;
        tick();
        bus.s_arvalid = 1'b0; bus.st_tvalid = 1'b1; bus.st_tdata = dv(10);
        #1;
        check("t2_b0_rvalid", 512'(bus.s_rvalid), 512'(1'b1));
        check("t2_b0_rid",    512'(bus.s_rid),    512'(6'd1));
        check("t2_b0_rlast",  512'(bus.s_rlast),  512'(1'b1));
        tick();
        bus.st_tdata = dv(11);
        #1;
        check("t2_b1_rvalid", 512'(bus.s_rvalid), 512'(1'b1));
        check("t2_b1_rid",    512'(bus.s_rid),    512'(6'd2));
        check("t2_b1_rlast",  512'(bus.s_rlast),  512'(1'b0));
        check("t2_b1_rdata",  bus.s_rdata,        dv(11));
        tick();
        bus.st_tdata = dv(12);
        #1;
        check("t2_b2_rvalid", 512'(bus.s_rvalid), 512'(1'b1));
        check("t2_b2_rid",    512'(bus.s_rid),    512'(6'd2));
        check("t2_b2_rlast",  512'(bus.s_rlast),  512'(1'b1));
        tick();
        bus.st_tvalid = 1'b0;
        #1;
        check("t2_done_rvalid", 512'(bus.s_rvalid), 512'(1'b0));

        // T3: fill the AR FIFO (first command is already held by the FSM)
        for (int k = 0; k < 5; k++) begin
            bus.s_arid = 6'(8 + k); bus.s_arlen = 8'd0; bus.s_arvalid = 1'b1;
            tick();
        end
        bus.s_arvalid = 1'b0;
        #1;
        check("t3_full_arready", 512'(bus.s_arready), 512'(1'b0));
        check("t3_nostream_rvalid", 512'(bus.s_rvalid), 512'(1'b0));
        bus.st_tvalid = 1'b1; bus.st_tdata = dv(20);
        #1;
        check("t3_first_rid", 512'(bus.s_rid), 512'(6'd8));
        tick();
        check("t3_arready_back", 512'(bus.s_arready), 512'(1'b1));
        for (int k = 9; k < 13; k++) begin
            bus.st_tdata = dv(k + 12);
            #1;
            check("t3_rvalid", 512'(bus.s_rvalid), 512'(1'b1));
            check("t3_rid",    512'(bus.s_rid),    512'(k));
            check("t3_rlast",  512'(bus.s_rlast),  512'(1'b1));
            tick();
        end
        bus.st_tvalid = 1'b0;
        #1;
        check("t3_done_rvalid", 512'(bus.s_rvalid), 512'(1'b0));

        // T4: rready toggling across an 8-beat burst
        bus.s_arid = 6'd7; bus.s_arlen = 8'd7; bus.s_arvalid = 1'b1;
        tick();
        bus.s_arvalid = 1'b0;
        idx = 0; nr = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            bus.s_rready = 1'((cyc & 1) == 1);
            bus.st_tvalid = (idx < 8);
            bus.st_tdata = dv(100 + idx);
            #1;
            if (bus.s_rvalid === 1'b1) begin
                check("t4_rdata", bus.s_rdata,       dv(100 + idx));
                check("t4_rid",   512'(bus.s_rid),   512'(6'd7));
                check("t4_rlast", 512'(bus.s_rlast), 512'(idx == 7));
                if (bus.s_rready) nr++;
            end
            cons = bus.st_tvalid & bus.st_tready;
            tick();
            if (cons) idx++;
        end
        check("t4_consumed", 512'(idx), 512'(8));
        check("t4_rbeats",   512'(nr),  512'(8));
        check("t4_done_rvalid", 512'(bus.s_rvalid), 512'(1'b0));
        bus.s_rready = 1'b1;

        // T5: len=255 gives 256 beats, rlast only on the last
        bus.s_arid = 6'd1; bus.s_arlen = 8'd255; bus.s_arvalid = 1'b1;
        tick();
        bus.s_arvalid = 1'b0; bus.st_tvalid = 1'b1;
        cnt = 0;
        for (int cyc = 0; cyc < 300 && cnt < 256; cyc++) begin
            bus.st_tdata = dv(cnt);
            #1;
            if (bus.s_rvalid === 1'b1) begin
                check("t5_rlast", 512'(bus.s_rlast), 512'(cnt == 255));
                cnt++;
            end
            tick();
        end
        check("t5_beats", 512'(cnt), 512'(256));
        bus.st_tvalid = 1'b0;
        #1;
        check("t5_done_rvalid", 512'(bus.s_rvalid), 512'(1'b0));

        // T6: wlast ahead of AW, then B ordering with bready held low
        bus.s_bready = 1'b0;
        bus.mon_wvalid = 1'b1; bus.mon_wready = 1'b1; bus.mon_wlast = 1'b1;
        tick(); tick();
        bus.mon_wvalid = 1'b0; bus.mon_wready = 1'b0; bus.mon_wlast = 1'b0;
        #1;
        check("t6_no_aw_bvalid", 512'(bus.s_bvalid), 512'(1'b0));
        bus.s_awid = 6'd3; bus.s_awvalid = 1'b1;
        tick();
        bus.s_awid = 6'd4;
        tick();
        bus.s_awvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("t6_hold_bvalid", 512'(bus.s_bvalid), 512'(1'b1));
            check("t6_hold_bid",    512'(bus.s_bid),    512'(6'd3));
            check("t6_bresp",       512'(bus.s_bresp),  512'(2'b00));
            tick();
        end
        bus.s_bready = 1'b1;
        #1;
        check("t6_b0_bid", 512'(bus.s_bid), 512'(6'd3));
        tick();
        check("t6_gap_bvalid", 512'(bus.s_bvalid), 512'(1'b0));
        tick();
        check("t6_b1_bvalid", 512'(bus.s_bvalid), 512'(1'b1));
        check("t6_b1_bid",    512'(bus.s_bid),    512'(6'd4));
        tick();
        check("t6_drained_bvalid", 512'(bus.s_bvalid), 512'(1'b0));
        bus.s_awid = 6'd9; bus.s_awvalid = 1'b1;
        tick();
        bus.s_awvalid = 1'b0;
        tick(); tick();
        check("t6_pend_zero_bvalid", 512'(bus.s_bvalid), 512'(1'b0));
        bus.mon_wvalid = 1'b1; bus.mon_wready = 1'b1; bus.mon_wlast = 1'b1;
        tick();
        bus.mon_wvalid = 1'b0; bus.mon_wready = 1'b0; bus.mon_wlast = 1'b0;
        tick();
        check("t6_b2_bvalid", 512'(bus.s_bvalid), 512'(1'b1));
        check("t6_b2_bid",    512'(bus.s_bid),    512'(6'd9));
        tick();
        check("t6_b2_done", 512'(bus.s_bvalid), 512'(1'b0));

`ifdef RESP_FRAMER_TIMEOUT_EN
        // T7: one beat then a stall of TIMEOUT_CYC cycles -> SLVERR remainder
        bus.s_arid = 6'd6; bus.s_arlen = 8'd3; bus.s_arvalid = 1'b1;
        tick();
        bus.s_arvalid = 1'b0; bus.st_tvalid = 1'b1; bus.st_tdata = dv(50);
        #1;
        wait_rvalid("t7_wait");
        check("t7_b0_rresp", 512'(bus.s_rresp), 512'(2'b00));
        tick();
        bus.st_tvalid = 1'b0;
        #1;
        n = 0;
        while (bus.s_rvalid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("t7_stall_cycles", 512'(n), 512'(16));
        for (int b = 0; b < 3; b++) begin
            check("t7_rvalid", 512'(bus.s_rvalid),  512'(1'b1));
            check("t7_rresp",  512'(bus.s_rresp),   512'(2'b10));
            check("t7_rdata",  bus.s_rdata,         512'd0);
            check("t7_tready", 512'(bus.st_tready), 512'(1'b0));
            check("t7_rlast",  512'(bus.s_rlast),   512'(b == 2));
            tick();
        end
        check("t7_done_rvalid", 512'(bus.s_rvalid), 512'(1'b0));
`endif

        // T8: reset in the middle of a burst abandons it
        bus.s_arid = 6'd2; bus.s_arlen = 8'd3; bus.s_arvalid = 1'b1;
        tick();
        bus.s_arvalid = 1'b0; bus.st_tvalid = 1'b1; bus.st_tdata = dv(60);
        #1;
        wait_rvalid("t8_wait");
        tick();
        check("t8_mid_rvalid", 512'(bus.s_rvalid), 512'(1'b1));
        rst_n = 1'b0;
        #1;
        check("t8_rst_rvalid",  512'(bus.s_rvalid),  512'(1'b0));
        check("t8_rst_tready",  512'(bus.st_tready), 512'(1'b0));
        check("t8_rst_arready", 512'(bus.s_arready), 512'(1'b0));
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check("t8_after_rvalid",  512'(bus.s_rvalid),  512'(1'b0));
        check("t8_after_arready", 512'(bus.s_arready), 512'(1'b1));
        bus.st_tvalid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
